// File: rtl/intc_seq_pkg.sv
// intc_seq_pkg: shared types and constants for the interrupt dispatch sequencer.
package intc_seq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FETCH, DISPATCH} state_t;
  typedef logic [2:0] level_t;
  localparam logic [7:0] NMI_VECTOR_DEFAULT = 8'd7;
  localparam int VEC_ENTRY_W = 32;
  typedef logic [VEC_ENTRY_W-1:0] vec_entry_t;
endpackage

// File: rtl/intc_dispatch_sequencer_if.sv
// intc_dispatch_sequencer_if: controller, CPU and vector-fetch signals of the sequencer.
interface intc_dispatch_sequencer_if #(parameter int NEST_DEPTH = 8);
  import intc_seq_pkg::*;
  logic irq_req;
  logic [7:0] irq_vector;
  level_t irq_level;
  logic cpu_int_req;
  logic [7:0] cpu_vector;
  logic cpu_int_ack;
  logic cpu_rte;
  logic cpu_exr_we;
  level_t cpu_exr_wdata;
  logic vec_fetch_req;
  vec_entry_t vec_fetch_addr;
  logic vec_fetch_ready;
  vec_entry_t vec_fetch_data;
  logic handler_valid;
  vec_entry_t handler_pc;
  logic exc_handling;
  level_t exr;
  logic [$clog2(NEST_DEPTH):0] nest_depth;
  logic nest_overflow;
  logic fetch_err;
  modport master (
    input irq_req, irq_vector, irq_level, cpu_int_ack, cpu_rte, cpu_exr_we, cpu_exr_wdata,
          vec_fetch_ready, vec_fetch_data,
    output cpu_int_req, cpu_vector, vec_fetch_req, vec_fetch_addr, handler_valid, handler_pc,
           exc_handling, exr, nest_depth, nest_overflow, fetch_err
  );
  modport slave (
    output irq_req, irq_vector, irq_level, cpu_int_ack, cpu_rte, cpu_exr_we, cpu_exr_wdata,
           vec_fetch_ready, vec_fetch_data,
    input cpu_int_req, cpu_vector, vec_fetch_req, vec_fetch_addr, handler_valid, handler_pc,
          exc_handling, exr, nest_depth, nest_overflow, fetch_err
  );
endinterface

// File: rtl/intc_level_stack.sv
// intc_level_stack: LIFO of mask levels; a push while full overwrites the top entry.
module intc_level_stack
  import intc_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  level_t                   din,
  output level_t                   top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  level_t mem [DEPTH];
  logic [AW-1:0] last;
  always_comb begin
    last = AW'(depth - DW'(1));
    full = depth == DW'(DEPTH);
    empty = depth == '0;
    top = mem[last];
  end
  always_ff @(posedge clk)
    if (push) mem[full ? last : AW'(depth)] <= din;
  always_ff @(posedge clk) begin
    if (rst) depth <= '0;
    else if (push && !full) depth <= depth + DW'(1);
    else if (pop) depth <= depth - DW'(1);
  end
endmodule

// File: rtl/intc_dispatch_sequencer.sv
// intc_dispatch_sequencer: request/ack handshake, vector fetch and EXR nesting for interrupt entry.
module intc_dispatch_sequencer
  import intc_seq_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0000,
  parameter int          NEST_DEPTH    = 8,
  parameter int          FETCH_TIMEOUT = 16,
  parameter logic [7:0]  NMI_VECTOR    = NMI_VECTOR_DEFAULT
) (
  input logic clk,
  input logic rst,
  intc_dispatch_sequencer_if.master bus
);
  localparam int DW = $clog2(NEST_DEPTH) + 1;
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  state_t state;
  level_t exr, lat_lvl, top;
  logic [CW-1:0] tcnt;
  logic [DW-1:0] depth;
  logic full, empty, push, pop, timeout, is_nmi, qualify;
  logic cpu_int_req, vec_fetch_req, handler_valid, exc_handling, nest_overflow, fetch_err;
  logic [7:0] cpu_vector;
  vec_entry_t vec_fetch_addr, handler_pc;
  always_comb begin
    is_nmi = bus.irq_vector == NMI_VECTOR;
    qualify = bus.irq_req && (is_nmi || (bus.irq_level > exr && !full));
    timeout = tcnt == CW'(FETCH_TIMEOUT - 1) && !bus.vec_fetch_ready;
    push = state == REQ && bus.cpu_int_ack;
    pop = (state == IDLE && bus.cpu_rte && !empty) || (state == FETCH && timeout);
  end
  intc_level_stack #(.DEPTH(NEST_DEPTH)) u_stack (
    .clk, .rst, .push, .pop, .din(exr), .top, .depth, .full, .empty
  );
  // cpu_vector doubles as the vector latch for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      exr <= 3'd7;
      lat_lvl <= '0;
      tcnt <= '0;
      cpu_int_req <= 1'b0;
      cpu_vector <= '0;
      vec_fetch_req <= 1'b0;
      vec_fetch_addr <= '0;
      handler_valid <= 1'b0;
      handler_pc <= '0;
      exc_handling <= 1'b0;
      nest_overflow <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      handler_valid <= 1'b0;
      exc_handling <= 1'b0;
      if (push && full) nest_overflow <= 1'b1;
      case (state)
        IDLE:
          if (pop) exr <= top;
          else if (bus.cpu_exr_we) exr <= bus.cpu_exr_wdata;
          else if (qualify) begin
            cpu_vector <= bus.irq_vector;
            lat_lvl <= is_nmi ? 3'd7 : bus.irq_level;
            cpu_int_req <= 1'b1;
            state <= REQ;
          end
        REQ:
          if (bus.cpu_int_ack) begin
            exr <= lat_lvl;
            cpu_int_req <= 1'b0;
            vec_fetch_req <= 1'b1;
            vec_fetch_addr <= VECTOR_BASE + 32'({cpu_vector, 2'b00});
            tcnt <= '0;
            state <= FETCH;
          end else if (!bus.irq_req && cpu_vector != NMI_VECTOR) begin
            cpu_int_req <= 1'b0;
            state <= IDLE;
          end
        FETCH:
          if (bus.vec_fetch_ready) begin
            handler_pc <= bus.vec_fetch_data;
            handler_valid <= 1'b1;
            exc_handling <= 1'b1;
            vec_fetch_req <= 1'b0;
            state <= DISPATCH;
          end else if (timeout) begin
            fetch_err <= 1'b1;
            exr <= top;
            vec_fetch_req <= 1'b0;
            state <= IDLE;
          end else tcnt <= tcnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.cpu_int_req = cpu_int_req;
  assign bus.cpu_vector = cpu_vector;
  assign bus.vec_fetch_req = vec_fetch_req;
  assign bus.vec_fetch_addr = vec_fetch_addr;
  assign bus.handler_valid = handler_valid;
  assign bus.handler_pc = handler_pc;
  assign bus.exc_handling = exc_handling;
  assign bus.exr = exr;
  assign bus.nest_depth = depth;
  assign bus.nest_overflow = nest_overflow;
  assign bus.fetch_err = fetch_err;
endmodule
